// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN classifier datapath.
// Holds the argmax FSM encoding and fc3 output-layer sizing.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } argmax_state_t;

  localparam int CNN_SCORE_W = 22;
  localparam int CNN_N_CLASS = 10;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_argmax_if.sv
// Score-vector in / argmax-result out handshake bundle.
// master drives vectors and out_ready; slave is the argmax block.
interface layer_argmax_if
  import cnn_pkg::*;
#(
  parameter int SCORE_W = CNN_SCORE_W,
  parameter int N_CLASS = CNN_N_CLASS
);

  localparam int IDX_W = idx_width(N_CLASS);

  logic               in_valid;
  logic               in_ready;
  logic [SCORE_W-1:0] scores [N_CLASS];
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   class_idx;
  logic [SCORE_W-1:0] max_score;
  logic               tie;

  modport master (
    output in_valid,
    output scores,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  class_idx,
    input  max_score,
    input  tie
  );

  modport slave (
    input  in_valid,
    input  scores,
    input  out_ready,
    output in_ready,
    output out_valid,
    output class_idx,
    output max_score,
    output tie
  );

endinterface

// File: rtl/layer_argmax.sv
// Captures a vector of fc3 scores and serially scans for the max.
// One unsigned compare per cycle; lowest index wins on a tie.
module layer_argmax
  import cnn_pkg::*;
#(
  parameter int SCORE_W = CNN_SCORE_W,
  parameter int N_CLASS = CNN_N_CLASS
) (
  input logic          clk,
  input logic          rst_n,
  layer_argmax_if.slave bus
);

  localparam int IDX_W = idx_width(N_CLASS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_CLASS - 1);
  localparam logic [IDX_W-1:0] FIRST =
    IDX_W'((N_CLASS > 1) ? 1 : 0);

  argmax_state_t      state;
  argmax_state_t      state_nxt;
  logic [SCORE_W-1:0] sreg [N_CLASS];
  logic [SCORE_W-1:0] best;
  logic [SCORE_W-1:0] best_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_nxt;
  logic               tie;
  logic               tie_nxt;
  logic               accept;
  logic [SCORE_W-1:0] cur;

  assign accept = bus.in_valid && (state == IDLE);
  assign cur    = sreg[ptr];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: capture, scan to the last entry, hand off
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == IDLE: begin
        if (accept) begin
          state_nxt = (N_CLASS == 1) ? DONE : SCAN;
        end
      end
      state == SCAN: begin
        if (ptr == LAST) begin
          state_nxt = DONE;
        end
      end
      state == DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake flags and the running result
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.class_idx = idx;
    bus.max_score = best;
    bus.tie       = tie;
  end

  // Compare/update step; equal keeps the earlier index
  always_comb begin
    best_nxt = best;
    idx_nxt  = idx;
    tie_nxt  = tie;
    ptr_nxt  = ptr;
    if (accept) begin
      best_nxt = bus.scores[0];
      idx_nxt  = '0;
      tie_nxt  = 1'b0;
      ptr_nxt  = FIRST;
    end else if (state == SCAN) begin
      if (cur > best) begin
        best_nxt = cur;
        idx_nxt  = ptr;
        tie_nxt  = 1'b0;
      end else if (cur == best) begin
        tie_nxt  = 1'b1;
      end
      if (ptr != LAST) begin
        ptr_nxt = ptr + IDX_W'(1);
      end
    end
  end

  // Result and scan-pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best <= '0;
      idx  <= '0;
      tie  <= 1'b0;
      ptr  <= '0;
    end else begin
      best <= best_nxt;
      idx  <= idx_nxt;
      tie  <= tie_nxt;
      ptr  <= ptr_nxt;
    end
  end

  // Score capture, only on the accept edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLASS; i++) begin
        sreg[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N_CLASS; i++) begin
        sreg[i] <= bus.scores[i];
      end
    end
  end

endmodule

// File: tb/tb_layer_argmax.sv
// Self-checking bench for layer_argmax.
// Directed and random vectors against a whole-vector argmax model.
module tb_layer_argmax;
  import cnn_pkg::*;

  localparam int SW = CNN_SCORE_W;
  localparam int NC = CNN_N_CLASS;
  localparam int IW = idx_width(NC);
  localparam int LAT = NC - 1;

  typedef logic [SW-1:0] vec_t [NC];

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  layer_argmax_if #(.SCORE_W(SW), .N_CLASS(NC)) bus ();

  layer_argmax #(.SCORE_W(SW), .N_CLASS(NC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: max over the vector, first index holding it,
  // tie when the max appears more than once.
  task automatic model(input vec_t v, output int ei,
                       output logic [SW-1:0] em, output logic et);
    int cnt;
    em = '0;
    foreach (v[i]) if (v[i] > em) em = v[i];
    ei = -1;
    cnt = 0;
    foreach (v[i]) begin
      if (v[i] == em) begin
        cnt++;
        if (ei < 0) ei = i;
      end
    end
    et = (cnt > 1);
  endtask

  function automatic vec_t rand_vec(input bit narrow);
    vec_t v;
    foreach (v[i]) begin
      if (narrow) v[i] = SW'($urandom_range(0, 7));
      else        v[i] = SW'($urandom);
    end
    return v;
  endfunction

  // Accept v, scramble the inputs, then wait for out_valid.
  task automatic launch(input vec_t v, output int lat);
    bus.scores   = v;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    bus.scores   = rand_vec(1'b0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    vec_t z;
    foreach (z[i]) z[i] = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.scores    = z;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.class_idx !== IW'(0) || bus.max_score !== SW'(0) ||
        bus.tie !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b idx=%0d max=%0d tie=%b want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.class_idx,
               bus.max_score, bus.tie);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_directed;
    vec_t tab [4];
    int ei, lat;
    logic [SW-1:0] em;
    logic et;
    tab[0] = '{5, 9, 3, 100, 7, 0, 2, 1, 4, 8};
    tab[1] = '{0, 50, 0, 0, 50, 0, 0, 0, 0, 50};
    tab[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    foreach (tab[3][i]) tab[3][i] = 22'h3FFFFE;
    tab[3][9] = 22'h3FFFFF;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      model(tab[t], ei, em, et);
      launch(tab[t], lat);
      checks++;
      if (lat !== LAT) begin
        errors++;
        $display("FAIL dir%0d latency: got %0d want %0d", t, lat, LAT);
      end
      checks++;
      if (bus.class_idx !== IW'(ei) || bus.max_score !== em ||
          bus.tie !== et) begin
        errors++;
        $display("FAIL dir%0d result: idx=%0d max=%0h tie=%b want %0d %0h %b",
                 t, bus.class_idx, bus.max_score, bus.tie, ei, em, et);
      end
      tick;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
          bus.class_idx !== IW'(ei) || bus.max_score !== em) begin
        errors++;
        $display("FAIL dir%0d handoff: vld=%b rdy=%b idx=%0d max=%0h want 0 1 %0d %0h",
                 t, bus.out_valid, bus.in_ready, bus.class_idx,
                 bus.max_score, ei, em);
      end
    end
  endtask

  task automatic test_backpressure;
    vec_t a, b;
    int ai, bi, lat;
    logic [SW-1:0] am, bm;
    logic at, bt;
    a = rand_vec(1'b1);
    b = rand_vec(1'b0);
    model(a, ai, am, at);
    model(b, bi, bm, bt);
    bus.out_ready = 1'b0;
    launch(a, lat);
    for (int c = 0; c < 5; c++) begin
      bus.scores   = b;
      bus.in_valid = 1'b1;
      tick;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.class_idx !== IW'(ai) || bus.max_score !== am ||
          bus.tie !== at) begin
        errors++;
        $display("FAIL hold%0d: vld=%b rdy=%b idx=%0d max=%0h tie=%b want 1 0 %0d %0h %b",
                 c, bus.out_valid, bus.in_ready, bus.class_idx,
                 bus.max_score, bus.tie, ai, am, at);
      end
    end
    bus.out_ready = 1'b1;
    tick;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: vld=%b rdy=%b want 0 1",
               bus.out_valid, bus.in_ready);
    end
    launch(b, lat);
    checks++;
    if (lat !== LAT || bus.class_idx !== IW'(bi) ||
        bus.max_score !== bm || bus.tie !== bt) begin
      errors++;
      $display("FAIL second: lat=%0d idx=%0d max=%0h tie=%b want %0d %0d %0h %b",
               lat, bus.class_idx, bus.max_score, bus.tie,
               LAT, bi, bm, bt);
    end
    tick;
  endtask

  task automatic test_reset_mid_scan;
    vec_t v;
    int ei, lat;
    logic [SW-1:0] em;
    logic et;
    bus.out_ready = 1'b1;
    bus.scores    = rand_vec(1'b0);
    bus.in_valid  = 1'b1;
    tick;
    bus.in_valid  = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.class_idx !== IW'(0) || bus.max_score !== SW'(0) ||
        bus.tie !== 1'b0) begin
      errors++;
      $display("FAIL abort: rdy=%b vld=%b idx=%0d max=%0h tie=%b want 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.class_idx,
               bus.max_score, bus.tie);
    end
    #2;
    rst_n = 1'b1;
    tick;
    foreach (v[i]) v[i] = SW'(i + 1);
    model(v, ei, em, et);
    launch(v, lat);
    checks++;
    if (lat !== LAT || bus.class_idx !== IW'(ei) ||
        bus.max_score !== em || bus.tie !== et) begin
      errors++;
      $display("FAIL after_abort: lat=%0d idx=%0d max=%0h tie=%b want %0d %0d %0h %b",
               lat, bus.class_idx, bus.max_score, bus.tie,
               LAT, ei, em, et);
    end
    tick;
  endtask

  task automatic test_random;
    vec_t v;
    int ei, lat;
    logic [SW-1:0] em;
    logic et;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      v = rand_vec(n[0]);
      model(v, ei, em, et);
      launch(v, lat);
      checks++;
      if (lat !== LAT || bus.class_idx !== IW'(ei) ||
          bus.max_score !== em || bus.tie !== et) begin
        errors++;
        $display("FAIL rand%0d: lat=%0d idx=%0d max=%0h tie=%b want %0d %0d %0h %b",
                 n, lat, bus.class_idx, bus.max_score, bus.tie,
                 LAT, ei, em, et);
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid_scan;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
